alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters, such as the execute stage and a multicycle helper unit. It accepts one operation at a time through a valid/ready handshake and registers the operands that drive the ALU. It captures the ALU result and flags into output registers, then holds the response until the granted requester accepts it. Arbitration is round-robin or fixed-priority.

## Interface
- FAIR, default 1: 1 selects round-robin on a tie; 0 selects fixed priority, where port 0 always wins a tie.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  the operation is accepted when both valid and ready are high at a rising edge.
- req0_opcode / req1_opcode  in  5  ALU opcode (00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra).
- req0_shamt / req1_shamt  in  5  shift amount.
- req0_operandA / req1_operandA, req0_operandB / req1_operandB  in  32  operands.
- rsp0_valid / rsp1_valid  out  1  the response is for that port.
- rsp0_ready / rsp1_ready  in  1  the requester accepts the response.
- rsp_result  out  32  registered ALU result; shared by both ports.
- rsp_isNotEqual, rsp_isLessThan, rsp_overflow  out  1  registered ALU flags; shared by both ports.
- alu_operandA, alu_operandB  out  32  registered; drive the ALU.
- alu_opcode, alu_shamt  out  5  registered; drive the ALU.
- alu_result  in  32  combinational output of the ALU.
- alu_isNotEqual, alu_isLessThan, alu_overflow  in  1  combinational ALU flags.

## Operation
- FSM states are IDLE, EXEC and RESP, with a 1-bit grant register (grant_id) and a 1-bit last_grant register.
- **IDLE: winner selection**
  - Only req0_valid high: port 0 wins.
  - Only req1_valid high: port 1 wins.
  - Both high, FAIR=1: the port that is not last_grant wins.
  - Both high, FAIR=0: port 0 wins.
- **IDLE: ready**
  - req_ready is combinational and high only for the winner.
  - The loser's ready and both readies outside IDLE are 0.
- **IDLE: accept**
  - On accept, the winner's opcode, shamt and operands are latched into the alu_* registers.
  - grant_id is set to the winner and the FSM moves to EXEC.
- **EXEC (exactly 1 cycle)**
  - The alu_* registers stay stable.
  - At the end of the cycle, alu_result and the three flags are captured into the rsp_* registers and the FSM moves to RESP.
- **RESP**
  - rsp{grant_id}_valid is 1; the other port's rsp_valid is 0.
  - When rsp{grant_id}_ready is high: last_grant is set to grant_id and the FSM returns to IDLE.
  - The non-granted port's rsp_ready is ignored.
- **Holding**
  - The alu_* and rsp_* registers hold their last values outside capture events; they are never cleared except by reset.
- **Pass-through**
  - Flags are forwarded raw from the ALU. rsp_overflow is meaningful only for add/sub, and the block does not qualify it.
- **Requester behaviour**
  - A requester may drop valid before acceptance without side effects.
  - Its operands must be stable while valid is high.

## Timing
- **Reset values**
  - FSM=IDLE, grant_id=0, last_grant=1, so port 0 wins the first tie.
  - All alu_* and rsp_* registers are 0.
  - rsp0_valid = rsp1_valid = 0.
- **Ready under reset**
  - req_ready is 0 while reset is asserted.
  - After reset is released, req_ready follows the IDLE rules.
- **Latency**
  - Accept at edge k.
  - alu_* updated after edge k.
  - rsp_* captured at edge k+1; rsp_valid is high from edge k+1.
- **Zero-wait response**
  - With rsp_ready held high, rsp_valid lasts 1 cycle.
  - The FSM is in IDLE after edge k+2 and the next accept can occur at edge k+3.
  - Sustained throughput is one operation per 3 cycles.
- **Backpressure**
  - If rsp_ready is low, RESP holds indefinitely with rsp_result and the flags stable.
  - Both req_ready stay 0 during that time.
- **Reset mid-operation**
  - Reset asserted in EXEC or RESP aborts the operation immediately (asynchronous).
  - No response is delivered and state returns to the reset values.
- **Simultaneous events**
  - A new request arriving in the same cycle as a RESP handshake is not accepted until the following IDLE cycle.

## Test plan
- **Single op, port 0:** after reset, req0 add A=0x00000005, B=0x00000003.
  - req0_ready=1 in the same cycle.
  - rsp0_valid 2 edges later (rsp_valid high from edge k+1) with rsp_result=0x00000008 and rsp_isNotEqual=1.
  - rsp1_valid stays 0 throughout.
- **Round-robin tie, FAIR=1:** both ports hold valid continuously, port 0 sub 7-7, port 1 or 0xF0|0x0F.
  - Grants go 0, 1, 0, 1.
  - Port 0 responses: rsp_result=0x00000000, rsp_isNotEqual=0.
  - Port 1 responses: rsp_result=0x000000FF.
- **Fixed priority, FAIR=0:** same stimulus as the round-robin case.
  - Port 0 is granted every time; req1_ready never goes high.
- **Backpressure:** rsp1_ready held low for 10 cycles on a port-1 sll of 0x00000001 by shamt 4.
  - rsp1_valid stays high with rsp_result=0x00000010 stable.
  - Both req_ready stay 0 during the stall.
  - The handshake completes on the edge where rsp1_ready rises.
- **Overflow pass-through:** add 0x7FFFFFFF + 0x00000001.
  - rsp_result=0x80000000, rsp_overflow=1.
- **Reset mid-EXEC:** assert reset in the EXEC cycle of an add.
  - Outputs clear immediately to the reset values and no rsp_valid is issued.
  - The next request after reset is accepted normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// One operation is in flight at a time: IDLE accepts, EXEC lets the ALU
// settle on the registered operands, RESP holds the captured result until
// the granted requester takes it. Ties are broken round-robin (FAIR=1) or
// in favour of port 0 (FAIR=0).
module alu_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  // Requester port 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_opcode,
  input  logic [4:0]  req0_shamt,
  input  logic [31:0] req0_operandA,
  input  logic [31:0] req0_operandB,
  // Requester port 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_opcode,
  input  logic [4:0]  req1_shamt,
  input  logic [31:0] req1_operandA,
  input  logic [31:0] req1_operandB,
  // Responses (data shared, valid per port)
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_isNotEqual,
  output logic        rsp_isLessThan,
  output logic        rsp_overflow,
  // Shared ALU
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_isNotEqual,
  input  logic        alu_isLessThan,
  input  logic        alu_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        grant_id_q, grant_id_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] alu_operand_a_q, alu_operand_a_d;
  logic [31:0] alu_operand_b_q, alu_operand_b_d;
  logic [4:0]  alu_opcode_q, alu_opcode_d;
  logic [4:0]  alu_shamt_q, alu_shamt_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_not_equal_q, rsp_not_equal_d;
  logic        rsp_less_than_q, rsp_less_than_d;
  logic        rsp_overflow_q, rsp_overflow_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;

  logic        any_req;
  logic        win_id;
  logic        accept;
  logic        rsp_ready_g;

  // Pick the winner in IDLE and raise ready for that port only.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win_id = FAIR ? ~last_grant_q : 1'b0;
    end else begin
      win_id = ~req0_valid;
    end
    // Ready is gated by reset so nothing looks acceptable while the
    // asynchronous reset is still holding the state.
    accept     = (state_q == IDLE) && any_req && !reset;
    req0_ready = accept && !win_id;
    req1_ready = accept && win_id;
  end

  // Next-state and datapath capture for the IDLE/EXEC/RESP sequence.
  always_comb begin
    // NOTE: every _d starts as its _q (hold), so no path leaves a signal
    // unassigned and no latch is inferred.
    state_d         = state_q;
    grant_id_d      = grant_id_q;
    last_grant_d    = last_grant_q;
    alu_operand_a_d = alu_operand_a_q;
    alu_operand_b_d = alu_operand_b_q;
    alu_opcode_d    = alu_opcode_q;
    alu_shamt_d     = alu_shamt_q;
    rsp_result_d    = rsp_result_q;
    rsp_not_equal_d = rsp_not_equal_q;
    rsp_less_than_d = rsp_less_than_q;
    rsp_overflow_d  = rsp_overflow_q;
    rsp0_valid_d    = rsp0_valid_q;
    rsp1_valid_d    = rsp1_valid_q;
    rsp_ready_g     = grant_id_q ? rsp1_ready : rsp0_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          alu_operand_a_d = win_id ? req1_operandA : req0_operandA;
          alu_operand_b_d = win_id ? req1_operandB : req0_operandB;
          alu_opcode_d    = win_id ? req1_opcode   : req0_opcode;
          alu_shamt_d     = win_id ? req1_shamt    : req0_shamt;
          grant_id_d      = win_id;
          state_d         = EXEC;
        end
      end
      EXEC: begin
        // The ALU has had a full cycle on stable operands; take its output.
        rsp_result_d    = alu_result;
        rsp_not_equal_d = alu_isNotEqual;
        rsp_less_than_d = alu_isLessThan;
        rsp_overflow_d  = alu_overflow;
        rsp0_valid_d    = ~grant_id_q;
        rsp1_valid_d    = grant_id_q;
        state_d         = RESP;
      end
      RESP: begin
        // Only the granted port's ready matters; the other is ignored.
        if (rsp_ready_g) begin
          last_grant_d = grant_id_q;
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and response registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_id_q      <= 1'b0;
      last_grant_q    <= 1'b1;
      // NOTE: the datapath registers are cleared too because their values
      // are directly visible on the ports and must read 0 after reset.
      alu_operand_a_q <= '0;
      alu_operand_b_q <= '0;
      alu_opcode_q    <= '0;
      alu_shamt_q     <= '0;
      rsp_result_q    <= '0;
      rsp_not_equal_q <= 1'b0;
      rsp_less_than_q <= 1'b0;
      rsp_overflow_q  <= 1'b0;
      rsp0_valid_q    <= 1'b0;
      rsp1_valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      grant_id_q      <= grant_id_d;
      last_grant_q    <= last_grant_d;
      alu_operand_a_q <= alu_operand_a_d;
      alu_operand_b_q <= alu_operand_b_d;
      alu_opcode_q    <= alu_opcode_d;
      alu_shamt_q     <= alu_shamt_d;
      rsp_result_q    <= rsp_result_d;
      rsp_not_equal_q <= rsp_not_equal_d;
      rsp_less_than_q <= rsp_less_than_d;
      rsp_overflow_q  <= rsp_overflow_d;
      rsp0_valid_q    <= rsp0_valid_d;
      rsp1_valid_q    <= rsp1_valid_d;
    end
  end

  assign alu_operandA   = alu_operand_a_q;
  assign alu_operandB   = alu_operand_b_q;
  assign alu_opcode     = alu_opcode_q;
  assign alu_shamt      = alu_shamt_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_isNotEqual = rsp_not_equal_q;
  assign rsp_isLessThan = rsp_less_than_q;
  assign rsp_overflow   = rsp_overflow_q;
  assign rsp0_valid     = rsp0_valid_q;
  assign rsp1_valid     = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a round-robin instance driven by directed and
// random traffic against a transaction-level reference model and scoreboard,
// plus a fixed-priority instance that sees a permanent tie.
module tb_alu_arbiter;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  typedef struct packed {
    logic [31:0] result;
    logic        ne;
    logic        lt;
    logic        ovf;
  } alu_out_t;

  typedef struct {
    bit       port;
    alu_out_t out;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [4:0]  req_opcode[2];
  logic [4:0]  req_shamt [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_result;
  logic        rsp_ne, rsp_lt, rsp_ovf;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op, alu_sh;
  alu_out_t    alu_o;

  // Fixed-priority instance signals
  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [31:0] fp_rsp_result;
  logic        fp_rsp_ne, fp_rsp_lt, fp_rsp_ovf;
  logic [31:0] fp_alu_a, fp_alu_b;
  logic [4:0]  fp_alu_op, fp_alu_sh;
  alu_out_t    fp_alu_o;
  int          fp_rsp_count = 0;

  // Reference model state
  int          m_phase = 0;   // 0 free, 1 computing, 2 response offered
  bit          m_grant = 1'b0;
  bit          m_last  = 1'b1;
  exp_t        sb_q[$];
  int          grant_log[$];
  logic [33:0] rsp_log[$];    // {port, ne, result}
  bit          rnd_done = 1'b0;

  always #5 clock = ~clock;

  // Behavioural ALU, used both as the shared ALU and as the expected value.
  function automatic alu_out_t alu_ref(input logic [4:0] op, input logic [4:0] sh,
                                       input logic [31:0] a, input logic [31:0] b);
    alu_out_t o;
    o = '0;
    case (op)
      OP_ADD: begin
        o.result = a + b;
        o.ovf = (a[31] == b[31]) && (o.result[31] != a[31]);
      end
      OP_SUB: begin
        o.result = a - b;
        o.ovf = (a[31] != b[31]) && (o.result[31] != a[31]);
      end
      OP_AND: o.result = a & b;
      OP_OR:  o.result = a | b;
      OP_SLL: o.result = a << sh;
      OP_SRA: o.result = $signed(a) >>> sh;
      default: o.result = 32'd0;
    endcase
    o.ne = (a != b);
    o.lt = ($signed(a) < $signed(b));
    return o;
  endfunction

  // Who should win in a free cycle, from the arbitration rules.
  function automatic bit pick(input logic v0, input logic v1, input bit last, input bit fair);
    if (v0 && v1) return fair ? !last : 1'b0;
    return v0 ? 1'b0 : 1'b1;
  endfunction

  assign alu_o    = alu_ref(alu_op, alu_sh, alu_a, alu_b);
  assign fp_alu_o = alu_ref(fp_alu_op, fp_alu_sh, fp_alu_a, fp_alu_b);

  alu_arbiter #(.FAIR(1'b1)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]),
    .req0_opcode(req_opcode[0]), .req0_shamt(req_shamt[0]),
    .req0_operandA(req_a[0]), .req0_operandB(req_b[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]),
    .req1_opcode(req_opcode[1]), .req1_shamt(req_shamt[1]),
    .req1_operandA(req_a[1]), .req1_operandB(req_b[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp_result(rsp_result), .rsp_isNotEqual(rsp_ne),
    .rsp_isLessThan(rsp_lt), .rsp_overflow(rsp_ovf),
    .alu_operandA(alu_a), .alu_operandB(alu_b),
    .alu_opcode(alu_op), .alu_shamt(alu_sh),
    .alu_result(alu_o.result), .alu_isNotEqual(alu_o.ne),
    .alu_isLessThan(alu_o.lt), .alu_overflow(alu_o.ovf)
  );

  // Permanent tie: port 0 sub 7-7, port 1 or 0xF0|0x0F, responses always taken.
  alu_arbiter #(.FAIR(1'b0)) dut_fp (
    .clock(clock), .reset(reset),
    .req0_valid(1'b1), .req0_ready(fp_req0_ready),
    .req0_opcode(OP_SUB), .req0_shamt(5'd0),
    .req0_operandA(32'd7), .req0_operandB(32'd7),
    .req1_valid(1'b1), .req1_ready(fp_req1_ready),
    .req1_opcode(OP_OR), .req1_shamt(5'd0),
    .req1_operandA(32'h0000_00F0), .req1_operandB(32'h0000_000F),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(1'b1),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(1'b1),
    .rsp_result(fp_rsp_result), .rsp_isNotEqual(fp_rsp_ne),
    .rsp_isLessThan(fp_rsp_lt), .rsp_overflow(fp_rsp_ovf),
    .alu_operandA(fp_alu_a), .alu_operandB(fp_alu_b),
    .alu_opcode(fp_alu_op), .alu_shamt(fp_alu_sh),
    .alu_result(fp_alu_o.result), .alu_isNotEqual(fp_alu_o.ne),
    .alu_isLessThan(fp_alu_o.lt), .alu_overflow(fp_alu_o.ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on each edge, advance the transaction-level view and
  // push the expected response when an operation is accepted.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_grant <= 1'b0;
      m_last  <= 1'b1;
      sb_q.delete();
    end else begin
      case (m_phase)
        0: if (req_valid[0] || req_valid[1]) begin
          m_grant <= pick(req_valid[0], req_valid[1], m_last, 1'b1);
          sb_q.push_back('{pick(req_valid[0], req_valid[1], m_last, 1'b1),
                           alu_ref(req_opcode[pick(req_valid[0], req_valid[1], m_last, 1'b1)],
                                   req_shamt [pick(req_valid[0], req_valid[1], m_last, 1'b1)],
                                   req_a     [pick(req_valid[0], req_valid[1], m_last, 1'b1)],
                                   req_b     [pick(req_valid[0], req_valid[1], m_last, 1'b1)])});
          m_phase <= 1;
        end
        1: m_phase <= 2;
        default: if (rsp_ready[m_grant]) begin
          m_last  <= m_grant;
          m_phase <= 0;
        end
      endcase
    end
  end

  // Monitor: compares handshake signals with the model and pops the
  // scoreboard whenever the DUT presents a response.
  always @(negedge clock) begin
    if (reset) begin
      check("ready0_in_reset", req_ready[0], 1'b0);
      check("ready1_in_reset", req_ready[1], 1'b0);
      check("rsp0_valid_in_reset", rsp_valid[0], 1'b0);
      check("rsp1_valid_in_reset", rsp_valid[1], 1'b0);
    end else begin
      check("req0_ready", req_ready[0], (m_phase == 0) && (req_valid[0] || req_valid[1]) &&
            !pick(req_valid[0], req_valid[1], m_last, 1'b1));
      check("req1_ready", req_ready[1], (m_phase == 0) && (req_valid[0] || req_valid[1]) &&
            pick(req_valid[0], req_valid[1], m_last, 1'b1));
      check("rsp0_valid", rsp_valid[0], (m_phase == 2) && !m_grant);
      check("rsp1_valid", rsp_valid[1], (m_phase == 2) && m_grant);
      for (int p = 0; p < 2; p++)
        if (req_valid[p] && req_ready[p]) grant_log.push_back(p);
      if (rsp_valid[0] || rsp_valid[1]) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          check("rsp_port",   rsp_valid[1], sb_q[0].port);
          check("rsp_result", rsp_result, sb_q[0].out.result);
          check("rsp_ne",     rsp_ne, sb_q[0].out.ne);
          check("rsp_lt",     rsp_lt, sb_q[0].out.lt);
          check("rsp_ovf",    rsp_ovf, sb_q[0].out.ovf);
          if (rsp_valid[sb_q[0].port] && rsp_ready[sb_q[0].port]) begin
            rsp_log.push_back({rsp_valid[1], rsp_ne, rsp_result});
            sb_q.pop_front();
          end
        end
      end
    end
  end

  // Fixed-priority instance: port 1 must never be granted under a permanent tie.
  always @(negedge clock) begin
    if (!reset) begin
      check("fp_req1_ready", fp_req1_ready, 1'b0);
      check("fp_rsp1_valid", fp_rsp1_valid, 1'b0);
      if (fp_rsp0_valid) begin
        check("fp_rsp_result", fp_rsp_result, 32'h0);
        check("fp_rsp_ne", fp_rsp_ne, 1'b0);
        fp_rsp_count <= fp_rsp_count + 1;
      end
    end
  end

  // Present one request and hold it until accepted; returns at edge+1.
  task automatic send(input int p, input logic [4:0] op, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b, output int waited);
    req_opcode[p] = op;
    req_shamt[p]  = sh;
    req_a[p]      = a;
    req_b[p]      = b;
    req_valid[p]  = 1'b1;
    waited = 0;
    for (;;) begin
      @(negedge clock);
      if (req_ready[p]) break;
      waited++;
      if (waited > 300) begin
        check("send_timeout", 1'b1, 1'b0);
        req_valid[p] = 1'b0;
        return;
      end
    end
    @(posedge clock); #1;
    req_valid[p] = 1'b0;
  endtask

  // Wait for the response on a port and compare it with fixed values.
  task automatic expect_rsp(input string name, input int p, input logic [31:0] result,
                            input logic ne, input logic ovf, input int latency);
    int n = 0;
    while (!rsp_valid[p] && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({name, "_seen"}, rsp_valid[p], 1'b1);
    check({name, "_latency"}, n, latency);
    check({name, "_result"}, rsp_result, result);
    check({name, "_ne"}, rsp_ne, ne);
    check({name, "_ovf"}, rsp_ovf, ovf);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || m_phase != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", n < 200, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic rand_stream(input int p, input int n);
    int w;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send(p, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 31)), a, b, w);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0; req_opcode[p] = '0; req_shamt[p] = '0;
      req_a[p] = '0; req_b[p] = '0; rsp_ready[p] = 1'b1;
    end

    // Reset state, with a request pending to show ready is held low.
    req_valid[0] = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_op", {27'd0, alu_op}, 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_flags", {29'd0, rsp_ne, rsp_lt, rsp_ovf}, 32'h0);
    check("rst_req0_ready", req_ready[0], 1'b0);
    req_valid[0] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Single add on port 0: ready same cycle, response two edges later.
    send(0, OP_ADD, 5'd0, 32'd5, 32'd3, w);
    check("add_ready_wait", w, 0);
    expect_rsp("add", 0, 32'h8, 1'b1, 1'b0, 2);
    wait_idle();

    // Round-robin tie from reset: grants 0,1,0,1.
    do_reset();
    grant_log.delete();
    rsp_log.delete();
    fork
      begin repeat (2) send(0, OP_SUB, 5'd0, 32'd7, 32'd7, w); end
      begin int w1; repeat (2) send(1, OP_OR, 5'd0, 32'hF0, 32'h0F, w1); end
    join
    wait_idle();
    check("rr_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("rr_grant_order", grant_log[i], i % 2);
    check("rr_rsp_count", rsp_log.size(), 4);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++)
      check("rr_rsp_value", rsp_log[i], (i % 2 == 0) ? {1'b0, 1'b0, 32'h0} : {1'b1, 1'b1, 32'hFF});

    // Backpressure on port 1 with port 0 waiting behind it.
    rsp_ready[1] = 1'b0;
    fork
      begin
        int w1;
        send(1, OP_SLL, 5'd4, 32'h1, 32'h0, w1);
        @(posedge clock);
        repeat (10) begin
          @(negedge clock);
          check("bp_rsp1_valid", rsp_valid[1], 1'b1);
          check("bp_result", rsp_result, 32'h10);
          check("bp_req0_ready", req_ready[0], 1'b0);
          check("bp_req1_ready", req_ready[1], 1'b0);
        end
        @(posedge clock); #1;
        rsp_ready[1] = 1'b1;
        @(posedge clock); #1;
        check("bp_released", rsp_valid[1], 1'b0);
      end
      begin
        @(posedge clock); #1;
        send(0, OP_ADD, 5'd0, 32'd2, 32'd2, w);
      end
    join
    wait_idle();

    // Overflow pass-through.
    send(0, OP_ADD, 5'd0, 32'h7FFF_FFFF, 32'h1, w);
    expect_rsp("ovf", 0, 32'h8000_0000, 1'b1, 1'b1, 2);
    wait_idle();

    // Reset during EXEC clears everything immediately.
    send(0, OP_ADD, 5'd0, 32'h10, 32'h20, w);
    #2;
    reset = 1'b1;
    #1;
    check("mid_alu_a", alu_a, 32'h0);
    check("mid_alu_b", alu_b, 32'h0);
    check("mid_rsp_result", rsp_result, 32'h0);
    check("mid_rsp_ovf", rsp_ovf, 1'b0);
    check("mid_rsp_valid", {rsp_valid[0], rsp_valid[1]}, 2'b00);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    send(1, OP_AND, 5'd0, 32'hFF00, 32'h0FF0, w);
    expect_rsp("post_rst", 1, 32'h0F00, 1'b1, 1'b0, 2);
    wait_idle();

    // Random traffic with random response backpressure.
    fork
      begin
        fork
          rand_stream(0, 25);
          rand_stream(1, 25);
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1;
          rsp_ready[0] = ($urandom_range(0, 9) < 7);
          rsp_ready[1] = ($urandom_range(0, 9) < 7);
        end
      end
    join
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    wait_idle();

    check("fp_rsp_count_min", fp_rsp_count >= 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
